// File: rtl/icache_fill_ctrl.sv
// Direct-mapped instruction cache (LINES x 4 x 16b) with a miss/refill controller
// that streams 4-word lines in from a fixed-latency pipelined instruction memory.
module icache_fill_ctrl #(
    parameter int LINES   = 16,
    parameter int MEM_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic        rd_en,
    output logic [15:0] instr,
    output logic        done,
    output logic        stall,
    output logic        err,
    output logic        mem_rd,
    output logic [15:0] mem_addr,
    input  logic        mem_valid,
    input  logic [15:0] mem_data
);
    localparam int IW = $clog2(LINES);
    localparam int TW = 16 - 3 - IW;
    // With very short memory latency the last return can land in the final FILL cycle.
    localparam bit EARLY_RET = (MEM_LAT < 1);

    typedef enum logic [1:0] {IDLE, FILL, DRAIN, COMPLETE} state_t;

    typedef struct packed {
        logic [TW-1:0] tag;
        logic [IW-1:0] idx;
        logic [1:0]    off;
    } miss_t;

    state_t state, state_nxt;
    miss_t  miss;
    logic [1:0] req_cnt, ret_cnt;

    logic [LINES-1:0]                 valid_q;
    logic [LINES-1:0][TW-1:0]         tag_q;
    logic [LINES-1:0][3:0][15:0]      data_q;

    logic [TW-1:0] a_tag;
    logic [IW-1:0] a_idx;
    logic [1:0]    a_off;
    logic          hit, accept, last_ret, start_fill;

    assign a_tag = addr[15:3+IW];
    assign a_idx = addr[3+IW-1:3];
    assign a_off = addr[2:1];
    assign hit   = valid_q[a_idx] && (tag_q[a_idx] == a_tag);

    assign accept     = mem_valid && (state == FILL || state == DRAIN);
    assign last_ret   = accept && (ret_cnt == 2'd3);
    assign start_fill = (state == IDLE) && rd_en && !addr[0] && !hit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (start_fill) state_nxt = FILL;
            FILL:     if (req_cnt == 2'd3)
                          state_nxt = (EARLY_RET && last_ret) ? COMPLETE : DRAIN;
            DRAIN:    if (last_ret) state_nxt = COMPLETE;
            COMPLETE: state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Outputs are forced low while reset is held, even though IDLE would otherwise decode rd_en.
    always_comb begin
        instr    = '0;
        done     = 1'b0;
        stall    = 1'b0;
        err      = 1'b0;
        mem_rd   = 1'b0;
        mem_addr = '0;
        if (rst) begin
            case (state)
                IDLE: if (rd_en) begin
                    if (addr[0]) err = 1'b1;
                    else if (hit) begin
                        done  = 1'b1;
                        instr = data_q[a_idx][a_off];
                    end else stall = 1'b1;
                end
                FILL: begin
                    stall    = 1'b1;
                    mem_rd   = 1'b1;
                    mem_addr = {miss.tag, miss.idx, req_cnt, 1'b0};
                end
                DRAIN: stall = 1'b1;
                COMPLETE: begin
                    done  = 1'b1;
                    instr = data_q[miss.idx][miss.off];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            miss    <= '0;
            req_cnt <= '0;
            ret_cnt <= '0;
            valid_q <= '0;
        end else begin
            if (start_fill) begin
                miss    <= '{tag: a_tag, idx: a_idx, off: a_off};
                req_cnt <= '0;
                ret_cnt <= '0;
            end
            if (state == FILL) req_cnt <= req_cnt + 2'd1;
            if (accept)        ret_cnt <= ret_cnt + 2'd1;
            if (last_ret)      valid_q[miss.idx] <= 1'b1;
        end
    end

    // Tag and data arrays carry no reset; the valid bits alone gate hits.
    always_ff @(posedge clk) begin
        if (accept)   data_q[miss.idx][ret_cnt] <= mem_data;
        if (last_ret) tag_q[miss.idx] <= miss.tag;
    end
endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Directed bench for icache_fill_ctrl with a fixed-latency memory model (word n = 0x1000+n).
module tb_icache_fill_ctrl;
    localparam int MEM_LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] addr = '0;
    logic        rd_en = 1'b0;
    logic [15:0] instr;
    logic        done, stall, err, mem_rd;
    logic [15:0] mem_addr;
    logic        mem_valid;
    logic [15:0] mem_data;

    int tests = 0;
    int fails = 0;

    icache_fill_ctrl #(.LINES(16), .MEM_LAT(MEM_LAT)) dut (
        .clk(clk), .rst(rst), .addr(addr), .rd_en(rd_en),
        .instr(instr), .done(done), .stall(stall), .err(err),
        .mem_rd(mem_rd), .mem_addr(mem_addr),
        .mem_valid(mem_valid), .mem_data(mem_data)
    );

    always #5 clk = ~clk;

    // Memory pipeline is not tied to the cache reset: in-flight reads still return.
    logic [MEM_LAT-1:0] rd_pipe = '0;
    logic [15:0]        ap [MEM_LAT];
    always @(posedge clk) begin
        rd_pipe[0] <= mem_rd;
        ap[0]      <= mem_addr;
        for (int i = 1; i < MEM_LAT; i++) begin
            rd_pipe[i] <= rd_pipe[i-1];
            ap[i]      <= ap[i-1];
        end
    end
    assign mem_valid = rd_pipe[MEM_LAT-1];
    assign mem_data  = mem_valid ? (16'h1000 + {1'b0, ap[MEM_LAT-1][15:1]}) : 16'h0000;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full miss scenario: request in cycle 0, done in cycle 5+MEM_LAT.
    task automatic miss_seq(input logic [15:0] a, input logic [15:0] exp_instr);
        logic [15:0] exp_ma;
        logic        exp_rd;
        rd_en = 1'b1;
        addr  = a;
        #1;
        tests++;
        if ({stall, done, err, mem_rd} !== 4'b1000) begin
            fails++;
            $display("FAIL miss_c0 a=%h {stall,done,err,mem_rd}=%b want 1000", a, {stall, done, err, mem_rd});
        end
        for (int c = 1; c < 5 + MEM_LAT; c++) begin
            step();
            exp_rd = (c >= 1 && c <= 4);
            exp_ma = exp_rd ? ((a & 16'hFFF8) + 16'(2 * (c - 1))) : 16'h0000;
            tests++;
            if ({stall, done, err, mem_rd} !== {1'b1, 1'b0, 1'b0, exp_rd} || mem_addr !== exp_ma) begin
                fails++;
                $display("FAIL miss_c%0d a=%h flags=%b mem_addr=%h want flags=%b mem_addr=%h",
                         c, a, {stall, done, err, mem_rd}, mem_addr, {3'b100, exp_rd}, exp_ma);
            end
        end
        step();
        tests++;
        if ({stall, done, err, mem_rd} !== 4'b0100 || instr !== exp_instr) begin
            fails++;
            $display("FAIL miss_done a=%h flags=%b instr=%h want flags=0100 instr=%h",
                     a, {stall, done, err, mem_rd}, instr, exp_instr);
        end
    endtask

    task automatic test_reset();
        rst   = 1'b0;
        rd_en = 1'b1;
        addr  = 16'h0000;
        step();
        step();
        tests++;
        if ({instr, done, stall, err, mem_rd, mem_addr} !== 36'h0) begin
            fails++;
            $display("FAIL reset_outputs instr=%h done=%b stall=%b err=%b mem_rd=%b mem_addr=%h want all 0",
                     instr, done, stall, err, mem_rd, mem_addr);
        end
        rd_en = 1'b0;
        #1 rst = 1'b1;
        step();
    endtask

    task automatic test_cold_miss();
        miss_seq(16'h0000, 16'h1000);
    endtask

    task automatic test_hit();
        step();
        addr = 16'h0004;
        #1;
        tests++;
        if ({stall, done, err, mem_rd} !== 4'b0100 || instr !== 16'h1002) begin
            fails++;
            $display("FAIL hit_0004 flags=%b instr=%h want 0100 1002", {stall, done, err, mem_rd}, instr);
        end
        step();
        addr = 16'h0006;
        #1;
        tests++;
        if ({stall, done, err, mem_rd} !== 4'b0100 || instr !== 16'h1003) begin
            fails++;
            $display("FAIL hit_0006 flags=%b instr=%h want 0100 1003", {stall, done, err, mem_rd}, instr);
        end
    endtask

    task automatic test_conflict();
        step();
        miss_seq(16'h0080, 16'h1040);
        step();
        miss_seq(16'h0000, 16'h1000);
    endtask

    task automatic test_back_to_back();
        // Index 4, offset 3, tag 1 straight after a COMPLETE cycle.
        step();
        miss_seq(16'h00A6, 16'h1053);
        step();
        addr = 16'h00A0;
        #1;
        tests++;
        if ({stall, done} !== 2'b01 || instr !== 16'h1050) begin
            fails++;
            $display("FAIL b2b_hit flags=%b instr=%h want 01 1050", {stall, done}, instr);
        end
    endtask

    task automatic test_misaligned();
        step();
        rd_en = 1'b1;
        addr  = 16'h0003;
        #1;
        tests++;
        if ({stall, done, err, mem_rd} !== 4'b0010 || instr !== 16'h0000) begin
            fails++;
            $display("FAIL misaligned flags=%b instr=%h want 0010 0000", {stall, done, err, mem_rd}, instr);
        end
        step();
        tests++;
        if ({stall, done, err, mem_rd} !== 4'b0010) begin
            fails++;
            $display("FAIL misaligned_hold flags=%b want 0010", {stall, done, err, mem_rd});
        end
        step();
        addr = 16'h0002;
        #1;
        tests++;
        if ({stall, done, err} !== 3'b010 || instr !== 16'h1001) begin
            fails++;
            $display("FAIL misaligned_then_hit flags=%b instr=%h want 010 1001", {stall, done, err}, instr);
        end
    endtask

    task automatic test_reset_mid_fill();
        step();
        rd_en = 1'b1;
        addr  = 16'h0100;
        step();
        step();
        step();
        tests++;
        if (mem_rd !== 1'b1 || mem_addr !== 16'h0104) begin
            fails++;
            $display("FAIL rmf_fill3 mem_rd=%b mem_addr=%h want 1 0104", mem_rd, mem_addr);
        end
        #1 rst = 1'b0;
        #1;
        tests++;
        if ({instr, done, stall, err, mem_rd, mem_addr} !== 36'h0) begin
            fails++;
            $display("FAIL rmf_async instr=%h done=%b stall=%b mem_rd=%b mem_addr=%h want all 0",
                     instr, done, stall, mem_rd, mem_addr);
        end
        rd_en = 1'b0;
        step();
        tests++;
        if (mem_valid !== 1'b1) begin
            fails++;
            $display("FAIL rmf_late_valid_present mem_valid=%b want 1", mem_valid);
        end
        #1 rst = 1'b1;
        #1;
        tests++;
        if ({done, stall, err, mem_rd} !== 4'b0000) begin
            fails++;
            $display("FAIL rmf_idle_late_valid flags=%b want 0000", {done, stall, err, mem_rd});
        end
        step();
        step();
        miss_seq(16'h0000, 16'h1000);
        step();
        addr = 16'h0002;
        #1;
        tests++;
        if ({stall, done} !== 2'b01 || instr !== 16'h1001) begin
            fails++;
            $display("FAIL rmf_refill_hit flags=%b instr=%h want 01 1001", {stall, done}, instr);
        end
    endtask

    task automatic test_idle();
        int bad;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            rd_en = 1'b0;
            addr  = 16'($urandom);
            #1;
            if ({done, stall, err, mem_rd} !== 4'b0000 || instr !== 16'h0000) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL idle bad_cycles=%0d want 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_hit();
        test_conflict();
        test_back_to_back();
        test_misaligned();
        test_reset_mid_fill();
        test_idle();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout tests=%0d", tests);
        $fatal(1, "timeout");
    end
endmodule
